// File: rtl/election_pkg.sv
// Shared constants and types for the decryption/tally pipeline blocks.
package election_pkg;

  localparam int unsigned BYTE_WIDTH            = 8;
  localparam int unsigned REGISTER_SIZE_DEFAULT = 32;

  typedef enum logic [1:0] {
    SER_COLLECT = 2'd0,
    SER_WAIT    = 2'd1,
    SER_ISSUE   = 2'd2,
    SER_GUARD   = 2'd3
  } ser_state_t;

  // Address/index width that stays at least one bit for degenerate sizes.
  function automatic int unsigned clog2_min1(input int unsigned value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/result_block_buffer.sv
// Simple dual-port NUM_BLOCKS x REGISTER_SIZE result store with a registered read port.
module result_block_buffer
  import election_pkg::*;
#(
  parameter int unsigned WIDTH = REGISTER_SIZE_DEFAULT,
  parameter int unsigned DEPTH = 64,
  localparam int unsigned AW   = clog2_min1(DEPTH)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Output register only is reset, so the transmitted byte reads 0 after reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/result_uart_serializer.sv
// Buffers a full multi-block result and streams its bytes to a UART transmitter.
// Optional trailing XOR checksum byte when RESULT_TX_CHECKSUM_EN is defined.
module result_uart_serializer
  import election_pkg::*;
#(
  parameter int unsigned REGISTER_SIZE = REGISTER_SIZE_DEFAULT,
  parameter int unsigned NUM_BLOCKS    = 64,
  parameter bit          MSB_FIRST     = 1'b0
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     valid_in,
  input  logic [REGISTER_SIZE-1:0] block_in,
  output logic                     ready_out,
  input  logic                     tx_busy_in,
  output logic [BYTE_WIDTH-1:0]    byte_out,
  output logic                     byte_valid_out,
  output logic                     busy_out,
  output logic                     done_out,
  output logic                     overflow_out
);

  localparam int unsigned LANES      = REGISTER_SIZE / BYTE_WIDTH;
  localparam int unsigned TOTAL_DATA = NUM_BLOCKS * LANES;
`ifdef RESULT_TX_CHECKSUM_EN
  localparam int unsigned TOTAL_TX   = TOTAL_DATA + 1;
`else
  localparam int unsigned TOTAL_TX   = TOTAL_DATA;
`endif
  localparam int unsigned BLK_W      = clog2_min1(NUM_BLOCKS);
  localparam int unsigned LANE_W     = clog2_min1(LANES);
  localparam int unsigned CNT_W      = $clog2(TOTAL_TX + 1);

  ser_state_t              state_q, state_d;
  logic [BLK_W-1:0]        blk_cnt_q, blk_cnt_d;
  logic [CNT_W-1:0]        byte_cnt_q, byte_cnt_d;
  logic [LANE_W-1:0]       lane_q, lane_d;
  logic                    ready_q, ready_d;
  logic                    byte_valid_q, byte_valid_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    overflow_q, overflow_d;

  logic                    wr_en_c, rd_en_c, all_sent_c;
  logic [CNT_W-1:0]        byte_idx_c;
  logic [BLK_W-1:0]        rd_addr_c;
  logic [LANE_W-1:0]       lane_sel_c;
  logic [REGISTER_SIZE-1:0] rd_data;
  logic [BYTE_WIDTH-1:0]   lane_byte_c;

`ifdef RESULT_TX_CHECKSUM_EN
  logic [BYTE_WIDTH-1:0]   csum_q, csum_d;
  logic [BYTE_WIDTH-1:0]   csum_out_q, csum_out_d;
  logic                    csum_sel_q, csum_sel_d;
`endif

  result_block_buffer #(
    .WIDTH (REGISTER_SIZE),
    .DEPTH (NUM_BLOCKS)
  ) u_buffer (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .wr_en   (wr_en_c),
    .wr_addr (blk_cnt_q),
    .wr_data (block_in),
    .rd_en   (rd_en_c),
    .rd_addr (rd_addr_c),
    .rd_data (rd_data)
  );

  // Map the send counter onto buffer block and byte lane, reversing for MSB-first order.
  always_comb begin
    byte_idx_c = MSB_FIRST ? (CNT_W'(TOTAL_DATA - 1) - byte_cnt_q) : byte_cnt_q;
    rd_addr_c  = BLK_W'(byte_idx_c / CNT_W'(LANES));
    lane_sel_c = LANE_W'(byte_idx_c % CNT_W'(LANES));
    all_sent_c = (byte_cnt_q == CNT_W'(TOTAL_TX));
  end

  assign lane_byte_c = BYTE_WIDTH'(rd_data >> (lane_q * BYTE_WIDTH));

  always_comb begin
    state_d    = state_q;
    blk_cnt_d  = blk_cnt_q;
    byte_cnt_d = byte_cnt_q;
    lane_d     = lane_q;
    done_d     = 1'b0;
    overflow_d = overflow_q;
    wr_en_c    = 1'b0;
    rd_en_c    = 1'b0;
`ifdef RESULT_TX_CHECKSUM_EN
    csum_d     = csum_q;
    csum_out_d = csum_out_q;
    csum_sel_d = csum_sel_q;
`endif

    if (valid_in && !ready_q) begin
      overflow_d = 1'b1;
    end

    case (state_q)
      SER_COLLECT: begin
        if (valid_in && ready_q) begin
          wr_en_c = 1'b1;
          if (blk_cnt_q == BLK_W'(NUM_BLOCKS - 1)) begin
            state_d    = SER_WAIT;
            blk_cnt_d  = '0;
            byte_cnt_d = '0;
`ifdef RESULT_TX_CHECKSUM_EN
            csum_d     = '0;
`endif
          end else begin
            blk_cnt_d = blk_cnt_q + BLK_W'(1);
          end
        end
      end
      // Read is only launched on the way into ISSUE so byte_out holds between triggers.
      SER_WAIT: begin
        if (!tx_busy_in) begin
          if (all_sent_c) begin
            state_d = SER_COLLECT;
            done_d  = 1'b1;
          end else begin
            state_d = SER_ISSUE;
            rd_en_c = 1'b1;
            lane_d  = lane_sel_c;
`ifdef RESULT_TX_CHECKSUM_EN
            csum_sel_d = (byte_cnt_q == CNT_W'(TOTAL_DATA));
            csum_out_d = csum_q;
`endif
          end
        end
      end
      SER_ISSUE: begin
        byte_cnt_d = byte_cnt_q + CNT_W'(1);
        state_d    = SER_GUARD;
`ifdef RESULT_TX_CHECKSUM_EN
        if (!csum_sel_q) begin
          csum_d = csum_q ^ lane_byte_c;
        end
`endif
      end
      SER_GUARD: begin
        state_d = SER_WAIT;
      end
      default: begin
        state_d = SER_COLLECT;
      end
    endcase

    // Ready stays low during the done cycle so it rises as done falls.
    ready_d      = (state_d == SER_COLLECT) && !done_d;
    busy_d       = (state_d != SER_COLLECT);
    byte_valid_d = (state_d == SER_ISSUE);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= SER_COLLECT;
      blk_cnt_q    <= '0;
      byte_cnt_q   <= '0;
      lane_q       <= '0;
      ready_q      <= 1'b1;
      byte_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      blk_cnt_q    <= blk_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      lane_q       <= lane_d;
      ready_q      <= ready_d;
      byte_valid_q <= byte_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      overflow_q   <= overflow_d;
    end
  end

`ifdef RESULT_TX_CHECKSUM_EN
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      csum_q     <= '0;
      csum_out_q <= '0;
      csum_sel_q <= 1'b0;
    end else begin
      csum_q     <= csum_d;
      csum_out_q <= csum_out_d;
      csum_sel_q <= csum_sel_d;
    end
  end

  assign byte_out = csum_sel_q ? csum_out_q : lane_byte_c;
`else
  assign byte_out = lane_byte_c;
`endif

  assign ready_out      = ready_q;
  assign byte_valid_out = byte_valid_q;
  assign busy_out       = busy_q;
  assign done_out       = done_q;
  assign overflow_out   = overflow_q;

endmodule

// File: tb/tb_result_uart_serializer.sv
// Scoreboard bench: LSB-first and MSB-first serializers driven side by side.
module tb_result_uart_serializer;

  localparam int unsigned RS     = 32;
  localparam int unsigned NB     = 2;
  localparam int unsigned NDATA  = NB * (RS / 8);
`ifdef RESULT_TX_CHECKSUM_EN
  localparam int unsigned NBYTES = NDATA + 1;
`else
  localparam int unsigned NBYTES = NDATA;
`endif
  localparam int unsigned BUSY_LEN = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid;
  logic [RS-1:0] blk;
  logic [1:0]    ready, tx_busy, bval, busy, done, ovf;
  logic [7:0]    bout [2];

  always #5 clk = ~clk;

  result_uart_serializer #(.REGISTER_SIZE(RS), .NUM_BLOCKS(NB), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clk_in(clk), .rst_in(rst), .valid_in(valid), .block_in(blk), .ready_out(ready[0]),
    .tx_busy_in(tx_busy[0]), .byte_out(bout[0]), .byte_valid_out(bval[0]),
    .busy_out(busy[0]), .done_out(done[0]), .overflow_out(ovf[0])
  );

  result_uart_serializer #(.REGISTER_SIZE(RS), .NUM_BLOCKS(NB), .MSB_FIRST(1'b1)) u_dut_msb (
    .clk_in(clk), .rst_in(rst), .valid_in(valid), .block_in(blk), .ready_out(ready[1]),
    .tx_busy_in(tx_busy[1]), .byte_out(bout[1]), .byte_valid_out(bval[1]),
    .busy_out(busy[1]), .done_out(done[1]), .overflow_out(ovf[1])
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int first_len = BUSY_LEN;
  int busy_cnt [2] = '{0, 0};
  int trig_cnt [2] = '{0, 0};
  int trig_cyc0[2] = '{0, 0};
  int trig_cyc1[2] = '{0, 0};
  int done_cnt [2] = '{0, 0};
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model: busy rises the cycle after a trigger and lasts a fixed count.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (bval[i]) busy_cnt[i] <= (trig_cnt[i] == 1) ? first_len : BUSY_LEN;
      else if (busy_cnt[i] != 0) busy_cnt[i] <= busy_cnt[i] - 1;
    end
  end
  assign tx_busy[0] = (busy_cnt[0] != 0);
  assign tx_busy[1] = (busy_cnt[1] != 0);

  // Scoreboard monitor, sampled away from the active edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (bval[i] === 1'b1) begin
        logic [7:0] e;
        trig_cnt[i]++;
        if (trig_cnt[i] == 1) trig_cyc0[i] = cyc;
        if (trig_cnt[i] == 2) trig_cyc1[i] = cyc;
        if (i == 0) begin
          check_eq("lsb_trigger_expected", 32'(exp_q0.size() > 0), 1);
          if (exp_q0.size() > 0) begin
            e = exp_q0.pop_front();
            check_eq("lsb_byte", 32'(bout[0]), 32'(e));
          end
        end else begin
          check_eq("msb_trigger_expected", 32'(exp_q1.size() > 0), 1);
          if (exp_q1.size() > 0) begin
            e = exp_q1.pop_front();
            check_eq("msb_byte", 32'(bout[1]), 32'(e));
          end
        end
      end
      if (done[i] === 1'b1) begin
        done_cnt[i]++;
        check_eq("done_after_last_byte", (i == 0) ? 32'(exp_q0.size()) : 32'(exp_q1.size()), 0);
      end
    end
  end

  task automatic send_stream(input logic [RS-1:0] b0, input logic [RS-1:0] b1, output int acc_cyc);
    logic [7:0] bytes [NDATA];
    logic [7:0] x;
    logic [RS-1:0] w;
    x = 8'h00;
    for (int j = 0; j < int'(NDATA); j++) begin
      w = (j < int'(RS / 8)) ? b0 : b1;
      bytes[j] = w[8 * (j % (RS / 8)) +: 8];
      x ^= bytes[j];
    end
    for (int j = 0; j < int'(NDATA); j++) begin
      exp_q0.push_back(bytes[j]);
      exp_q1.push_back(bytes[NDATA - 1 - j]);
    end
`ifdef RESULT_TX_CHECKSUM_EN
    exp_q0.push_back(x);
    exp_q1.push_back(x);
`endif
    for (int i = 0; i < 2; i++) begin
      trig_cnt[i] = 0;
      done_cnt[i] = 0;
    end
    acc_cyc = 0;
    for (int k = 0; k < int'(NB); k++) begin
      @(negedge clk);
      check_eq("ready_while_collecting", 32'(ready), 32'h3);
      valid = 1'b1;
      blk = (k == 0) ? b0 : b1;
      acc_cyc = cyc;
    end
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (done_cnt[0] != 0 && done_cnt[1] != 0) break;
    end
    check_eq({tag, "_done_lsb"}, 32'(done_cnt[0]), 1);
    check_eq({tag, "_done_msb"}, 32'(done_cnt[1]), 1);
    @(negedge clk);
    check_eq({tag, "_ready_after_done"}, 32'(ready), 32'h3);
    check_eq({tag, "_not_busy"}, 32'(busy), 32'h0);
    repeat (3) @(negedge clk);
    check_eq({tag, "_single_done"}, 32'(done_cnt[0] + done_cnt[1]), 2);
    check_eq({tag, "_byte_count_lsb"}, 32'(trig_cnt[0]), NBYTES);
    check_eq({tag, "_byte_count_msb"}, 32'(trig_cnt[1]), NBYTES);
  endtask

  task automatic wait_trig(input int n);
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (trig_cnt[0] >= n) break;
    end
    check_eq("trigger_reached", 32'(trig_cnt[0] >= n), 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_ready"}, 32'(ready), 32'h3);
    check_eq({tag, "_byte_valid"}, 32'(bval), 32'h0);
    check_eq({tag, "_busy"}, 32'(busy), 32'h0);
    check_eq({tag, "_done"}, 32'(done), 32'h0);
    check_eq({tag, "_overflow"}, 32'(ovf), 32'h0);
    check_eq({tag, "_byte_out"}, {16'h0, bout[1], bout[0]}, 32'h0);
  endtask

  initial begin
    int acc;
    rst = 1'b1;
    valid = 1'b0;
    blk = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;

    // Basic ordering and latency
    send_stream(32'h04030201, 32'h08070605, acc);
    wait_done("order");
    check_eq("first_trigger_latency", 32'(trig_cyc0[0] - acc), 2);
    check_eq("byte_spacing", 32'(trig_cyc1[0] - trig_cyc0[0]), BUSY_LEN + 2);

    // Long busy stall after the first trigger
    first_len = 100;
    send_stream($urandom, $urandom, acc);
    wait_done("stall");
    check_eq("stall_gap_lsb", 32'(trig_cyc1[0] - trig_cyc0[0]), 102);
    check_eq("stall_gap_msb", 32'(trig_cyc1[1] - trig_cyc0[1]), 102);
    first_len = BUSY_LEN;

    // Block presented while sending is dropped and flagged
    send_stream(32'h11223344, 32'h55667788, acc);
    wait_trig(1);
    @(negedge clk);
    valid = 1'b1;
    blk = 32'hDEADBEEF;
    @(negedge clk);
    valid = 1'b0;
    check_eq("overflow_set", 32'(ovf), 32'h3);
    wait_done("overflow");
    check_eq("overflow_sticky", 32'(ovf), 32'h3);

    // Reset in the middle of a send
    send_stream(32'h99AABBCC, 32'hDDEEFF00, acc);
    wait_trig(3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_outputs("mid_reset");
    exp_q0.delete();
    exp_q1.delete();
    send_stream(32'hA1B2C3D4, 32'h0F1E2D3C, acc);
    wait_done("after_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
